// File: rtl/fifo_to_com_if.sv
// FIFO read-port bundle between the outbound FIFO and the fifo_to_com serialiser.
// master: the reader (fifo_to_com) issuing fifo_re; slave: the FIFO supplying data.
interface fifo_to_com_if;
  logic [7:0] fifo_data_in;
  logic       fifo_empty;
  logic       fifo_re;

  modport master (
    input  fifo_data_in,
    input  fifo_empty,
    output fifo_re
  );

  modport slave (
    output fifo_data_in,
    output fifo_empty,
    input  fifo_re
  );
endinterface

// File: rtl/fifo_to_com.sv
// fifo_to_com: pops bytes from the outbound FIFO and sends each as an 8N1 UART
// frame on tx, keeping a running CRC-8 (poly 0x07, init 0x00, MSB first) over
// every byte sent.
// Optional feature macro: CRC_APPEND_EN -- when defined, send_crc in IDLE sends
// the current CRC as its own frame and clears the CRC.
module fifo_to_com #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  fifo_to_com_if.master fifo,
  output logic          tx,
  output logic          busy,
  output logic          byte_done,
  output logic [7:0]    crc,
  input  logic          crc_clear,
  input  logic          send_crc
);

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned BIT_W  = 3;

  localparam logic [CNT_W-1:0]  BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);
  localparam logic [DATA_W-1:0] CRC_POLY  = 8'h07;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WAIT  = 3'd1,
    LOAD  = 3'd2,
    START = 3'd3,
    DATA  = 3'd4,
    STOP  = 3'd5
`ifdef CRC_APPEND_EN
    ,
    CRCLD = 3'd6
`endif
  } state_e;

  state_e              state_q, state_d;
  logic                tx_q, tx_d;
  logic                fifo_re_q, fifo_re_d;
  logic                busy_q, busy_d;
  logic                byte_done_q, byte_done_d;
  logic [DATA_W-1:0]   crc_q, crc_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [CNT_W-1:0]    baud_q, baud_d;
  logic                baud_end_c;

`ifndef CRC_APPEND_EN
  // send_crc has no effect without the CRC append feature.
  logic unused_send_crc_c;
  assign unused_send_crc_c = send_crc;
`endif

  // One full-byte CRC-8 update, MSB first, no reflection, no final XOR.
  function automatic logic [DATA_W-1:0] crc8_step(input logic [DATA_W-1:0] c,
                                                   input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] r;
    r = c ^ d;
    for (int i = 0; i < int'(DATA_W); i++) begin
      r = r[DATA_W-1] ? (DATA_W'(r << 1) ^ CRC_POLY) : DATA_W'(r << 1);
    end
    return r;
  endfunction

  assign baud_end_c = (baud_q == BAUD_LAST);

  // Next-state and next-output logic for the transmit FSM.
  always_comb begin
    state_d   = state_q;
    tx_d      = tx_q;
    fifo_re_d = 1'b0;
    crc_d     = crc_q;
    shift_d   = shift_q;
    bit_d     = bit_q;
    baud_d    = baud_q;

    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
`ifdef CRC_APPEND_EN
        if (send_crc) begin
          state_d = CRCLD;
        end else
`endif
        if (crc_clear) begin
          crc_d = '0;
        end else if (enable && !fifo.fifo_empty) begin
          fifo_re_d = 1'b1;
          state_d   = WAIT;
        end
      end

      // FIFO data appears on fifo_data_in the cycle after the read strobe.
      WAIT: begin
        state_d = LOAD;
      end

      LOAD: begin
        shift_d = fifo.fifo_data_in;
        crc_d   = crc8_step(crc_q, fifo.fifo_data_in);
        tx_d    = 1'b0;
        baud_d  = '0;
        state_d = START;
      end

`ifdef CRC_APPEND_EN
      CRCLD: begin
        shift_d = crc_q;
        crc_d   = '0;
        tx_d    = 1'b0;
        baud_d  = '0;
        state_d = START;
      end
`endif

      START: begin
        if (baud_end_c) begin
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = shift_q[0];
          state_d = DATA;
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end

      // shift_q[0] is always the bit currently on the line.
      DATA: begin
        if (baud_end_c) begin
          baud_d = '0;
          if (bit_q == BIT_LAST) begin
            bit_d   = '0;
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            bit_d   = bit_q + BIT_W'(1);
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end

      STOP: begin
        if (baud_end_c) begin
          baud_d  = '0;
          state_d = IDLE;
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end

      default: begin
        tx_d    = 1'b1;
        baud_d  = '0;
        bit_d   = '0;
        state_d = IDLE;
      end
    endcase

    busy_d      = (state_d != IDLE);
    byte_done_d = (state_d == STOP) && (baud_d == BAUD_LAST);
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      tx_q        <= 1'b1;
      fifo_re_q   <= 1'b0;
      busy_q      <= 1'b0;
      byte_done_q <= 1'b0;
      crc_q       <= '0;
      shift_q     <= '0;
      bit_q       <= '0;
      baud_q      <= '0;
    end else begin
      state_q     <= state_d;
      tx_q        <= tx_d;
      fifo_re_q   <= fifo_re_d;
      busy_q      <= busy_d;
      byte_done_q <= byte_done_d;
      crc_q       <= crc_d;
      shift_q     <= shift_d;
      bit_q       <= bit_d;
      baud_q      <= baud_d;
    end
  end

  assign fifo.fifo_re = fifo_re_q;
  assign tx           = tx_q;
  assign busy         = busy_q;
  assign byte_done    = byte_done_q;
  assign crc          = crc_q;

endmodule
